// File: rtl/mac_array_acc.sv
// Mixed-precision (int8/int4/binary) dot-product engine with saturating running accumulator.
// Latency 2 cycles from last-beat accept to out_valid; a held result (out_valid && !out_ready) stalls every stage and drops in_ready.
module mac_array_acc #(
  parameter int NUM_PE = 4,
  parameter int ACC_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [1:0]            prec,
  input  logic [NUM_PE*8-1:0]   a8,
  input  logic [NUM_PE*8-1:0]   b8,
  input  logic [NUM_PE*4-1:0]   a4,
  input  logic [NUM_PE*4-1:0]   b4,
  input  logic [NUM_PE-1:0]     ab,
  input  logic [NUM_PE-1:0]     bb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_acc,
  output logic                  out_sat
);

  localparam int SUM_W = 17 + $clog2(NUM_PE);
  localparam int TW    = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic                   vld;
    logic                   last;
    logic [NUM_PE-1:0][15:0] prod;
  } s1_t;

  s1_t                      s1;
  logic [NUM_PE-1:0][15:0]  prod_d;
  logic signed [SUM_W-1:0]  sum;
  logic signed [TW-1:0]     t;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sat_t;
  logic                     clip;
  logic                     sticky;
  logic                     en;
  logic                     accept;

  function automatic logic [15:0] pe_prod(
    input logic [1:0] p,
    input logic [7:0] x8,
    input logic [7:0] y8,
    input logic [3:0] x4,
    input logic [3:0] y4,
    input logic       xb,
    input logic       yb
  );
    logic signed [15:0] r;
    logic signed [7:0]  p4;
    r  = '0;
    p4 = 8'($signed(x4)) * 8'($signed(y4));
    case (p)
      2'd0:    r = 16'($signed(x8)) * 16'($signed(y8));
      2'd1:    r = 16'(p4);
      2'd2:    r = (xb == yb) ? 16'h0001 : 16'hFFFF;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign en       = !(out_valid && !out_ready);
  assign in_ready = !clr && en;
  assign accept   = in_valid && in_ready;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      prod_d[i] = pe_prod(prec, a8[8*i +: 8], b8[8*i +: 8], a4[4*i +: 4], b4[4*i +: 4], ab[i], bb[i]);
    end
  end

  // Sum is sized so it can never overflow; only the accumulate step can clip.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      sum = sum + SUM_W'($signed(s1.prod[i]));
    end
  end

  always_comb begin
    t     = TW'(acc) + TW'(sum);
    clip  = t[ACC_W] ^ t[ACC_W-1];
    sat_t = t[ACC_W-1:0];
    if (clip) begin
      sat_t = t[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (clr) begin
      s1 <= '0;
    end else if (en) begin
      s1.vld <= accept;
      if (accept) begin
        s1.last <= in_last;
        s1.prod <= prod_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (en && s1.vld) begin
        if (s1.last) begin
          // Closing beat: publish and restart clean so vectors can run back-to-back.
          out_acc   <= sat_t;
          out_sat   <= sticky | clip;
          out_valid <= 1'b1;
          acc       <= '0;
          sticky    <= 1'b0;
        end else begin
          acc    <= sat_t;
          sticky <= sticky | clip;
        end
      end
    end
  end

endmodule

// File: doc/mac_array_acc.md
# mac_array_acc

Pipelined, parameterised mixed-precision dot-product engine with a running accumulator. Each accepted beat carries NUM_PE operand pairs in int8, int4 or binary (±1) precision. The per-PE products are summed and added into a saturating accumulator. The beat flagged last closes the vector and hands the result to an output register through a valid/ready handshake. It sits between the operand fetch stage and the requantisation/activation stage, and replaces the purely combinational sum-of-products array.

## Interface
- NUM_PE, 4: parallel processing elements per beat; ≥1.
- ACC_W, 32: accumulator/result width; must be ≥ 18+$clog2(NUM_PE).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock, asynchronous and active-high.
- clr  in  1  synchronous flush of pipeline, accumulator and output register.
- in_valid  in  1  beat present.
- in_ready  out  1  beat can be accepted.
- in_last  in  1  final beat of the current vector.
- prec  in  2  0=int8, 1=int4, 2=binary, 3=reserved (product 0).
- a8, b8  in  NUM_PE*8  signed int8 operands; PE i at bits [8i+7:8i].
- a4, b4  in  NUM_PE*4  signed int4 operands; PE i at [4i+3:4i].
- ab, bb  in  NUM_PE  binary operands; bit i belongs to PE i.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_acc  out  ACC_W  signed dot-product result.
- out_sat  out  1  saturation occurred anywhere in this vector.

## Operation
- Accept: a beat is accepted when in_valid && in_ready.
- Ready: in_ready = !clr && !(out_valid && !out_ready).
- Stall: en = !(out_valid && !out_ready). When en=0, every stage holds, including the stage-1 register and the accumulator.
- Stage 1, registered on accept:
  - int8: prod_i = a8_i*b8_i, 16-bit signed.
  - int4: prod_i = a4_i*b4_i, sign-extended.
  - binary: prod_i = +1 if ab_i==bb_i, else −1.
  - reserved: prod_i = 0.
- Stage 1 also registers last and s1_valid. prec is per beat; mixing precisions within a vector is legal.
- Stage 2 (when s1_valid && en):
  - sum = Σprod_i at full width (no overflow possible).
  - t = acc + sum, computed in ACC_W+1 bits.
  - Saturate t to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. If clipping occurs, set the sticky sat bit.
- Non-last beat: acc ← saturated t.
- Last beat:
  - out_acc ← saturated t; out_sat ← sticky|clip; out_valid ← 1.
  - acc ← 0 and sticky ← 0 in the same edge, so the next vector starts clean back-to-back.
- Output handshake:
  - out_valid && out_ready drops out_valid unless a new last result is written in the same edge; in that case out_valid stays 1 with the new data.
  - out_acc and out_sat are stable while out_valid && !out_ready.
- clr: on the next edge, s1_valid, acc, sticky and out_valid go to 0 and out_acc goes to 0. The beat presented in that cycle is not accepted. clr overrides stall.
- Single-beat vector (in_last on its only beat) is legal and yields that beat's sum.

## Timing
- Reset values: in_ready=1 (with clr=0), out_valid=0, out_acc=0, out_sat=0; acc, sticky and s1_valid are 0.
- Reset asserted mid-vector discards all partial state immediately.
- Latency: a last beat accepted at edge t gives out_valid=1 after edge t+1, i.e. 2 cycles.
- Throughput: 1 beat/cycle while out_ready is held high, including back-to-back vectors.
- Backpressure: out_valid && !out_ready deasserts in_ready combinationally in that same cycle. No beat is lost or duplicated.

## Test plan
- NUM_PE=4, int8, one last beat with a8={1,2,3,4}, b8={5,6,7,8} → out_acc=70, out_sat=0, out_valid 2 cycles after accept.
- int4 then binary then int8 in one 3-beat vector: a4 all −8, b4 all −8 (sum 256), then ab=4'b1010, bb=4'b1000 (sum 2), then a8 all −128, b8 all 127 (sum −65024) → out_acc=−64766.
- ACC_W=20, 10 beats of int8 −128×−128 on all 4 PEs → out_acc=524287 (clamped at 2^19−1), out_sat=1. The next vector starts clean with out_sat=0.
- Hold out_ready=0 with a result pending, then drive 5 more beats → in_ready=0 and out_acc stable. Release out_ready → all 5 beats are processed exactly once.
- Back-to-back single-beat vectors with out_ready=1 → one result per cycle, each correct, acc never leaks between vectors.
- Assert clr, and separately async rst, mid-vector → out_valid=0 and out_acc=0. The following vector {1,1,1,1}·{1,1,1,1} gives exactly 4.
